// File: rtl/data_stream_hs_packer.sv
// Stream byte packer: compacts sparse-strobe input beats into dense output words;
// only the last word of a packet may be partial. Optional checks: DATA_STREAM_HS_PACKER_ASSERT_EN.
module data_stream_hs_packer #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   s_data,
    input  logic [DATA_WIDTH/8-1:0] s_strb,
    input  logic                    s_last,
    input  logic                    s_valid,
    output logic                    s_ready,
    output logic [DATA_WIDTH-1:0]   m_data,
    output logic [DATA_WIDTH/8-1:0] m_strb,
    output logic                    m_last,
    output logic                    m_valid,
    input  logic                    m_ready
);

    localparam int N  = DATA_WIDTH / 8;
    localparam int CW = $clog2(2 * N + 1);
    localparam int BW = 2 * DATA_WIDTH;
    localparam logic [CW-1:0] N_C = CW'(N);
    localparam logic [CW-1:0] ONE = CW'(1);

    logic [BW-1:0] buf_q, buf_d;
    logic [CW-1:0] count_q, count_d;
    logic          flush_q, flush_d;

    logic          push, pop;
    logic [CW-1:0] popped, base, pc;
    logic [BW-1:0] comp, shifted;

    // Ready comes from state only, so there is no combinational path from m_ready.
    assign s_ready = !rst && (count_q <= N_C) && !flush_q;
    assign m_valid = (count_q >= N_C) || flush_q;
    assign m_last  = flush_q && (count_q <= N_C);

    assign push   = s_valid && s_ready;
    assign pop    = m_valid && m_ready;
    assign popped = pop ? ((count_q >= N_C) ? N_C : count_q) : '0;
    assign base   = count_q - popped;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        m_data = '0;
        m_strb = '0;
        for (int i = 0; i < N; i++) begin
            if (CW'(i) < count_q) begin
                m_strb[i]        = 1'b1;
                m_data[8*i +: 8] = buf_q[8*i +: 8];
            end
        end
    end

    // Enabled lanes are gathered in ascending order; pc ends as the popcount.
    always_comb begin
        comp = '0;
        pc   = '0;
        for (int i = 0; i < N; i++) begin
            if (s_strb[i]) begin
                comp = comp | (BW'(s_data[8*i +: 8]) << {pc, 3'b000});
                pc   = pc + ONE;
            end
        end
    end

    // Pop shifts first; a concurrent push appends at the post-pop fill level.
    always_comb begin
        shifted = buf_q >> {popped, 3'b000};
        buf_d   = shifted;
        count_d = base;
        flush_d = flush_q;
        if (push) begin
            buf_d   = shifted | (comp << {base, 3'b000});
            count_d = base + pc;
            if (s_last) flush_d = 1'b1;
        end
        if (pop && m_last) flush_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the byte buffer is reset too, so stale bytes can never leak into a lane after reset.
            buf_q   <= '0;
            count_q <= '0;
            flush_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            buf_q   <= buf_d;
            count_q <= count_d;
            flush_q <= flush_d;
        end
    end

`ifdef DATA_STREAM_HS_PACKER_ASSERT_EN
    a_s_hold: assert property (@(posedge clk) disable iff (rst)
        (s_valid && !s_ready) |=> (s_valid && $stable({s_data, s_strb, s_last})))
        else $error("s-port beat dropped or changed while stalled");

    a_m_hold: assert property (@(posedge clk) disable iff (rst)
        (m_valid && !m_ready) |=> (m_valid && $stable({m_data, m_strb, m_last})))
        else $error("m-port beat dropped or changed while stalled");

    a_count: assert property (@(posedge clk) disable iff (rst)
        count_q <= CW'(2 * N))
        else $error("fill count exceeds buffer size");

    a_strb: assert property (@(posedge clk) disable iff (rst)
        (m_strb & (m_strb + {{(N-1){1'b0}}, 1'b1})) == '0)
        else $error("m_strb not contiguous from lane 0");
`endif

endmodule

// File: tb/tb_data_stream_hs_packer.sv
// Self-checking bench for data_stream_hs_packer: directed scenarios plus random packets,
// scored against a byte-queue reference model.
module tb_data_stream_hs_packer;

    localparam int N = 4;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  strb;
        bit          last;
    } word_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] s_data;
    logic [3:0]  s_strb;
    logic        s_last;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] m_data;
    logic [3:0]  m_strb;
    logic        m_last;
    logic        m_valid;
    logic        m_ready;

    int n_cmp = 0;
    int n_bad = 0;
    bit rand_ready = 1'b0;

    logic [7:0] byte_q[$];
    word_t      exp_q[$];

    data_stream_hs_packer #(.DATA_WIDTH(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .s_data  (s_data),
        .s_strb  (s_strb),
        .s_last  (s_last),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .m_data  (m_data),
        .m_strb  (m_strb),
        .m_last  (m_last),
        .m_valid (m_valid),
        .m_ready (m_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Pop n bytes of the model stream into one expected output word.
    task automatic emit(input int n, input bit l);
        word_t w;
        w.data = '0;
        w.strb = '0;
        w.last = l;
        for (int i = 0; i < n; i++) begin
            w.data[8*i +: 8] = byte_q.pop_front();
            w.strb[i]        = 1'b1;
        end
        exp_q.push_back(w);
    endtask

    // Reference model: accepted bytes form a stream chopped into N-byte words;
    // the packet end flushes the remainder (or an empty word if nothing remains).
    always @(negedge clk) begin
        if (!rst && s_valid && s_ready) begin
            for (int i = 0; i < N; i++)
                if (s_strb[i]) byte_q.push_back(s_data[8*i +: 8]);
            if (s_last) begin
                if (byte_q.size() == 0) emit(0, 1'b1);
                while (byte_q.size() > 0)
                    emit((byte_q.size() > N) ? N : byte_q.size(), byte_q.size() <= N);
            end else begin
                while (byte_q.size() >= N) emit(N, 1'b0);
            end
        end
    end

    // Output monitor: every accepted output word is compared with the queue head.
    always @(negedge clk) begin
        word_t e;
        if (!rst && m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_word: got data %h strb %h last %0d, expected none",
                         m_data, m_strb, m_last);
            end else begin
                e = exp_q.pop_front();
                check("m_data", m_data, e.data);
                check("m_strb", {28'b0, m_strb}, {28'b0, e.strb});
                check("m_last", {31'b0, m_last}, {31'b0, e.last});
            end
        end
    end

    always @(posedge clk) begin
        if (rand_ready) begin
            #1;
            m_ready = ($urandom_range(0, 9) < 7);
        end
    end

    task automatic send(input logic [31:0] d, input logic [3:0] st, input bit l);
        s_data  = d;
        s_strb  = st;
        s_last  = l;
        s_valid = 1'b1;
        for (int t = 0; ; t++) begin
            @(negedge clk);
            if (s_ready) break;
            if (t > 2000) begin
                check("s_ready_wait", {31'b0, s_ready}, 32'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int total;
        int nb;
        logic [3:0] st;

        rst = 1'b1;
        s_data = '0; s_strb = '0; s_last = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
        #12;
        check("rst_s_ready", {31'b0, s_ready}, 32'd0);
        check("rst_m_valid", {31'b0, m_valid}, 32'd0);
        check("rst_m_data", m_data, 32'd0);
        check("rst_m_strb", {28'b0, m_strb}, 32'd0);
        check("rst_m_last", {31'b0, m_last}, 32'd0);
        #10 rst = 1'b0;
        idle(1);
        check("post_rst_s_ready", {31'b0, s_ready}, 32'd1);

        // Dense stream: one-cycle latency, back-to-back words.
        m_ready = 1'b1;
        send(32'h03020100, 4'hF, 1'b0);
        check("dense_latency_valid", {31'b0, m_valid}, 32'd1);
        check("dense_latency_data", m_data, 32'h03020100);
        send(32'h07060504, 4'hF, 1'b0);
        check("dense_b2b_valid", {31'b0, m_valid}, 32'd1);

        // Sparse merge: nothing after the first beat, one dense word after the second.
        idle(2);
        send(32'hDDCCBBAA, 4'h5, 1'b0);
        idle(2);
        check("sparse_no_output", {31'b0, m_valid}, 32'd0);
        send(32'h44332211, 4'h3, 1'b0);
        check("sparse_word", m_data, 32'h2211CCAA);

        // Partial tail: left-aligned last word; input closed until it pops.
        send(32'h000000AA, 4'h1, 1'b1);
        check("tail_s_ready", {31'b0, s_ready}, 32'd0);
        check("tail_strb", {28'b0, m_strb}, 32'h1);
        check("tail_last", {31'b0, m_last}, 32'd1);
        idle(1);
        check("tail_reopen", {31'b0, s_ready}, 32'd1);

        // Empty end: zero strobe with last emits one empty last beat.
        send(32'h12345678, 4'h0, 1'b1);
        check("empty_valid", {31'b0, m_valid}, 32'd1);
        check("empty_strb", {28'b0, m_strb}, 32'h0);
        check("empty_last", {31'b0, m_last}, 32'd1);
        idle(1);
        send(32'h12345678, 4'h0, 1'b0);
        idle(3);
        check("empty_nolast_quiet", {31'b0, m_valid}, 32'd0);

        // Backpressure: two full beats fill the buffer, the third stalls.
        m_ready = 1'b0;
        send(32'hA3A2A1A0, 4'hF, 1'b0);
        send(32'hB3B2B1B0, 4'hF, 1'b0);
        s_data = 32'hC3C2C1C0; s_strb = 4'hF; s_last = 1'b0; s_valid = 1'b1;
        repeat (3) @(negedge clk);
        check("bp_stall", {31'b0, s_ready}, 32'd0);
        check("bp_head", m_data, 32'hA3A2A1A0);
        m_ready = 1'b1;
        send(32'hC3C2C1C0, 4'hF, 1'b0);
        send(32'hD3D2D1D0, 4'hF, 1'b1);
        idle(6);
        check("bp_drained", 32'(exp_q.size()), 32'd0);

        // Reset mid-packet with buffered bytes and flush pending.
        m_ready = 1'b0;
        send(32'h00CCBBAA, 4'h7, 1'b1);
        idle(1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_m_valid", {31'b0, m_valid}, 32'd0);
        check("mid_rst_m_data", m_data, 32'd0);
        check("mid_rst_m_strb", {28'b0, m_strb}, 32'd0);
        check("mid_rst_s_ready", {31'b0, s_ready}, 32'd0);
        byte_q.delete();
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        m_ready = 1'b1;
        idle(1);
        send(32'h5A5B5C5D, 4'hF, 1'b1);
        idle(3);

        // Random packets under random backpressure.
        rand_ready = 1'b1;
        for (int p = 0; p < 150; p++) begin
            nb = $urandom_range(1, 5);
            total = 0;
            for (int b = 0; b < nb; b++) begin
                st = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom);
                // A zero-byte last beat after a word boundary has timing-dependent framing.
                if (b == nb - 1 && st == 4'h0 && total > 0 && (total % N) == 0) st = 4'h1;
                total += $countones(st);
                send($urandom, st, b == nb - 1);
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            end
        end
        rand_ready = 1'b0;
        #2 m_ready = 1'b1;

        for (int t = 0; t < 2000 && exp_q.size() > 0; t++) @(negedge clk);
        check("final_drain", 32'(exp_q.size()), 32'd0);
        idle(2);
        check("final_idle", {31'b0, m_valid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/data_stream_hs_packer.md
# data_stream_hs_packer

Stream byte packer: a slave on a ready/valid data stream with per-byte strobes that accepts beats with arbitrary (sparse) strobe patterns. It compacts the enabled bytes and re-emits them as a master stream of fully populated words. Only the final word of a packet may be partial, and it is left-aligned to lane 0. It sits at the consuming end of any producer that emits sparse strobes (DMA tails, unaligned sources), in front of sinks that require dense data.

## Interface
- DATA_WIDTH, 32, stream data width in bits; multiple of 8; N = DATA_WIDTH/8 byte lanes
- clk  in  1  clock; all logic rising-edge
- rst  in  1  reset, asynchronous assert, active-high
- s_data  in  DATA_WIDTH  input beat data; byte lane i = bits [8i+7:8i]
- s_strb  in  N  input byte enables, any pattern incl. all-zero
- s_last  in  1  marks final beat of a packet
- s_valid  in  1  input beat valid
- s_ready  out  1  packer can accept a beat
- m_data  out  DATA_WIDTH  packed output data
- m_strb  out  N  output byte enables, always contiguous from lane 0
- m_last  out  1  final word of a packet
- m_valid  out  1  output word valid
- m_ready  in  1  downstream accepts

## Operation
- Internal state:
  - byte buffer of 2N bytes
  - fill count 0..2N, width $clog2(2N+1)
  - flush_pending flag
- Push: s_valid & s_ready.
  - Enabled bytes of s_data are taken in ascending lane order and appended at buffer position count.
  - count += popcount(s_strb).
  - If s_last, flush_pending set.
- s_ready = (count <= N) & !flush_pending, derived from registers only, with no path from m_ready.
- m_valid = (count >= N) | flush_pending.
- m_data = low N buffer bytes; lanes at or above count are zero.
- m_strb = all ones if count >= N, else the low count bits set.
- m_last = flush_pending & (count <= N).
- Pop: m_valid & m_ready.
  - popped = min(count, N).
  - Buffer shifts down by popped bytes, zero-filling.
  - count -= popped.
  - If m_last, flush_pending clears.
- Simultaneous push and pop:
  - Shift first, then append at the post-pop count.
  - count_next = count - popped + popcount(s_strb).
- All-zero s_strb without s_last: accepted, no bytes stored, no output.
- All-zero s_strb with s_last:
  - If count == 0, one beat is emitted with m_strb = 0, m_last = 1, which preserves the packet boundary.
  - If count > 0, the last beat carries the residual bytes.
- A packet with exactly k·N bytes ends on a full word with m_last = 1; no extra empty beat follows.
- Once asserted, m_valid holds with m_data, m_strb and m_last stable until the pop. This follows from the registered state.

## Timing
- Reset values:
  - count = 0, flush_pending = 0, buffer = 0
  - m_valid = 0, m_data = 0, m_strb = 0, m_last = 0
  - s_ready forced 0 while rst is high, and 1 in the first cycle after release
- Latency: a push at edge k that makes count >= N gives m_valid = 1 in cycle k+1 (one-cycle latency).
- Throughput: with full strobes and m_ready held high, one word per cycle is sustained indefinitely (count oscillates at N).
- Backpressure: with m_ready = 0, at most 2N bytes are buffered. s_ready drops once count > N.
- During flush, s_ready = 0 until the m_last beat pops. The next packet's first beat can be pushed in the cycle after that pop.
- A rst assertion mid-packet immediately discards buffered bytes and the flush state. No output beat is emitted for the partial data.

## Configuration
- DATA_STREAM_HS_PACKER_ASSERT_EN defined: concurrent assertions are compiled in, with error reporting on violation. They check that:
  - on either port, valid does not drop, and data/strb/last do not change, while valid & !ready
  - count never exceeds 2N
  - m_strb is always contiguous from lane 0
- Undefined: no assertion code and no simulation-only logic; functionally identical RTL.

## Test plan
- **Dense stream (DATA_WIDTH = 32).** Stimulus: 0x03020100 then 0x07060504, both with strb 0xF, m_ready = 1. Required: the same two words with m_strb 0xF, first one cycle after push, back-to-back.
- **Sparse merge.** Stimulus: 0xDDCCBBAA with strb 0x5, then 0x44332211 with strb 0x3. Required: output 0x2211CCAA, strb 0xF; no output after the first beat.
- **Partial tail.** Stimulus: 0x000000AA with strb 0x1 and s_last. Required:
  - output 0x000000AA, m_strb 0x1, m_last 1
  - s_ready 0 until that beat pops
- **Empty end.** Stimulus: strb 0x0 with s_last on an empty buffer. Required: one beat with m_strb 0x0, m_last 1. The same stimulus without s_last produces no output.
- **Backpressure.** Stimulus: m_ready = 0, three full beats offered. Required:
  - two are accepted (count 8), third stalls with s_ready = 0
  - on releasing m_ready, all three words emerge in order with no loss
- **Reset mid-operation.** Stimulus: assert rst with count = 3 and flush_pending = 1. Required:
  - all outputs read zero within the same cycle
  - the post-reset stream is unaffected by the prior bytes
